// File: rtl/prog_loader_pkg.sv
// Shared opcodes, FSM state encoding and default control words for prog_loader.
// The VERIFY state exists only when PROG_LOADER_VERIFY_EN is defined.
package prog_loader_pkg;

    localparam logic [7:0] OP_SET_ADDR = 8'h01;
    localparam logic [7:0] OP_WRITE    = 8'h02;
    localparam logic [7:0] OP_TAKE     = 8'h03;
    localparam logic [7:0] OP_RELEASE  = 8'h04;

    localparam logic [31:0] CW_MEM_WRITE_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] CW_MEM_READ_DEFAULT  = 32'h0000_0000;

    typedef enum logic [2:0] {
        IDLE,
        ARG,
        TAKE,
        WR_SETUP,
        WR_STROBE,
        WR_HOLD
`ifdef PROG_LOADER_VERIFY_EN
        , VERIFY
`endif
    } state_t;

endpackage

// File: rtl/mem_write_seq.sv
// One memory write cycle: SETUP, STROBE, HOLD, plus a two-cycle read-back VERIFY
// when PROG_LOADER_VERIFY_EN is defined. Address and data are latched on start.
module mem_write_seq
    import prog_loader_pkg::*;
#(
    parameter logic [31:0] CW_MEM_WRITE = CW_MEM_WRITE_DEFAULT,
    parameter logic [31:0] CW_MEM_READ  = CW_MEM_READ_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] addr,
    input  logic [7:0]  data,
    input  logic [7:0]  bus_in,
    output logic        done,
    output logic        mismatch,
    output logic        verifying,
    output logic [15:0] addr_out,
    output logic [7:0]  data_out,
    output logic [31:0] cw_out,
    output state_t      state
);

    state_t      state_d;
    logic [15:0] addr_q;
    logic [7:0]  data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            state <= state_d;
            if (start && state == IDLE) begin
                addr_q <= addr;
                data_q <= data;
            end
        end
    end

    assign addr_out = addr_q;
    assign data_out = data_q;

`ifdef PROG_LOADER_VERIFY_EN
    // High on the second VERIFY cycle, where bus_in is sampled.
    logic verify_second_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) verify_second_q <= 1'b0;
        else     verify_second_q <= (state == VERIFY) && !verify_second_q;
    end
`else
    logic unused_verify;
    assign unused_verify = ^{bus_in, CW_MEM_READ};
`endif

    always_comb begin
        state_d   = state;
        done      = 1'b0;
        mismatch  = 1'b0;
        verifying = 1'b0;
        cw_out    = '0;
        case (state)
            IDLE:      if (start) state_d = WR_SETUP;
            WR_SETUP:  state_d = WR_STROBE;
            WR_STROBE: begin
                cw_out  = CW_MEM_WRITE;
                state_d = WR_HOLD;
            end
            WR_HOLD: begin
`ifdef PROG_LOADER_VERIFY_EN
                state_d = VERIFY;
`else
                done    = 1'b1;
                state_d = IDLE;
`endif
            end
`ifdef PROG_LOADER_VERIFY_EN
            VERIFY: begin
                verifying = 1'b1;
                cw_out    = CW_MEM_READ;
                if (verify_second_q) begin
                    done     = 1'b1;
                    mismatch = (bus_in != data_q);
                    state_d  = IDLE;
                end
            end
`endif
            default:   state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/prog_loader.sv
// Host-side loader: parses the command byte stream, owns the CPU buses while
// writing memory. Optional read-back verify via PROG_LOADER_VERIFY_EN.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter logic [31:0] CW_MEM_WRITE  = CW_MEM_WRITE_DEFAULT,
    parameter logic [31:0] CW_MEM_READ   = CW_MEM_READ_DEFAULT,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  cmd_data,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    output logic        ctrlen,
    output logic [31:0] cw_out,
    output logic        cw_oe,
    output logic [15:0] addr_out,
    output logic        addr_oe,
    output logic [7:0]  data_out,
    output logic        data_oe,
    input  logic [7:0]  bus_in,
    output logic        busy,
    output logic        err,
    output state_t      state_dbg
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    // Handshake: a byte moves on every rising edge where cmd_valid && cmd_ready.
    // WR_SETUP in state_q means "write in flight"; the sequencer owns the phases.
    state_t      state_q, state_d;
    logic [7:0]  op_q, op_d;
    logic        arg_hi_q, arg_hi_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic        owned_q, owned_d;
    logic        err_q, err_d;
    logic        pend_q, pend_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [3:0]  settle_q;
    logic        ready_en_q;

    logic        accept, seq_start, seq_done, seq_mismatch, seq_verifying;
    logic [7:0]  seq_data;
    state_t      seq_state;

    assign accept   = cmd_valid && cmd_ready;
    assign seq_data = (state_q == TAKE) ? wdata_q : cmd_data;

    mem_write_seq #(
        .CW_MEM_WRITE(CW_MEM_WRITE),
        .CW_MEM_READ (CW_MEM_READ)
    ) u_seq (
        .clk      (clk),
        .rst      (rst),
        .start    (seq_start),
        .addr     (addr_q),
        .data     (seq_data),
        .bus_in   (bus_in),
        .done     (seq_done),
        .mismatch (seq_mismatch),
        .verifying(seq_verifying),
        .addr_out (addr_out),
        .data_out (data_out),
        .cw_out   (cw_out),
        .state    (seq_state)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= '0;
            arg_hi_q   <= 1'b0;
            cnt_q      <= '0;
            addr_q     <= '0;
            owned_q    <= 1'b0;
            err_q      <= 1'b0;
            pend_q     <= 1'b0;
            wdata_q    <= '0;
            settle_q   <= '0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            arg_hi_q   <= arg_hi_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            owned_q    <= owned_d;
            err_q      <= err_d;
            pend_q     <= pend_d;
            wdata_q    <= wdata_d;
            settle_q   <= (state_q == TAKE) ? settle_q + 4'd1 : 4'd0;
            ready_en_q <= 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        arg_hi_d  = arg_hi_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        owned_d   = owned_q;
        err_d     = err_q || seq_mismatch;
        pend_d    = pend_q;
        wdata_d   = wdata_q;
        seq_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (cmd_data)
                        OP_SET_ADDR, OP_WRITE: begin
                            op_d     = cmd_data;
                            arg_hi_d = 1'b0;
                            state_d  = ARG;
                        end
                        OP_TAKE: begin
                            if (!owned_q) begin
                                pend_d  = 1'b0;
                                state_d = TAKE;
                            end
                        end
                        OP_RELEASE: owned_d = 1'b0;
                        default:    err_d = 1'b1;
                    endcase
                end
            end
            ARG: begin
                if (accept) begin
                    if (op_q == OP_SET_ADDR) begin
                        if (!arg_hi_q) begin
                            addr_d[7:0] = cmd_data;
                            arg_hi_d    = 1'b1;
                        end else begin
                            addr_d[15:8] = cmd_data;
                            state_d      = IDLE;
                        end
                    end else if (!arg_hi_q) begin
                        cnt_d    = cmd_data;
                        arg_hi_d = 1'b1;
                    end else begin
                        cnt_d   = cnt_q - 8'd1;
                        wdata_d = cmd_data;
                        if (owned_q) begin
                            seq_start = 1'b1;
                            state_d   = WR_SETUP;
                        end else begin
                            pend_d  = 1'b1;
                            state_d = TAKE;
                        end
                    end
                end
            end
            TAKE: begin
                if (settle_q == SETTLE_LAST) begin
                    owned_d = 1'b1;
                    pend_d  = 1'b0;
                    if (pend_q) begin
                        seq_start = 1'b1;
                        state_d   = WR_SETUP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            WR_SETUP: begin
                if (seq_done) state_d = (cnt_q == 8'd0) ? IDLE : ARG;
            end
            default: state_d = IDLE;
        endcase
        if (seq_start) addr_d = addr_q + 16'd1;
    end

    // Buses stay driven for as long as the loader owns them, to avoid float.
    assign cmd_ready = ready_en_q && (state_q == IDLE || state_q == ARG);
    assign busy      = !(state_q == IDLE || state_q == ARG);
    assign ctrlen    = !(state_q == TAKE || owned_q);
    assign cw_oe     = owned_q;
    assign addr_oe   = owned_q;
    assign data_oe   = owned_q && !seq_verifying;
    assign err       = err_q;
    assign state_dbg = (state_q == WR_SETUP) ? seq_state : state_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed steps plus randomized writes
// against an address/ownership model and an expected-write queue.
module tb_prog_loader;
    import prog_loader_pkg::*;

    localparam logic [31:0] CW_W   = 32'hA5A5_0001;
    localparam logic [31:0] CW_R   = 32'h5A5A_0002;
    localparam int          SETTLE = 2;
`ifdef PROG_LOADER_VERIFY_EN
    localparam int          PER    = 5;
`else
    localparam int          PER    = 3;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  cmd_data;
    logic        cmd_valid;
    logic        cmd_ready, ctrlen, cw_oe, addr_oe, data_oe, busy, err;
    logic [31:0] cw_out;
    logic [15:0] addr_out;
    logic [7:0]  data_out;
    logic [7:0]  bus_in;
    state_t      state_dbg;

    int          checks = 0;
    int          errors = 0;
    int          busy_cnt = 0;
    logic [23:0] exp_q[$];
    logic [7:0]  wr_data[$];
    logic [7:0]  tb_mem[0:65535];
    logic        force_zero = 1'b0;
    logic [15:0] m_addr;
    logic        m_owned;

    prog_loader #(
        .CW_MEM_WRITE (CW_W),
        .CW_MEM_READ  (CW_R),
        .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_data (cmd_data),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .ctrlen   (ctrlen),
        .cw_out   (cw_out),
        .cw_oe    (cw_oe),
        .addr_out (addr_out),
        .addr_oe  (addr_oe),
        .data_out (data_out),
        .data_oe  (data_oe),
        .bus_in   (bus_in),
        .busy     (busy),
        .err      (err),
        .state_dbg(state_dbg)
    );

    // Clock / memory read-back model
    always #5 clk = ~clk;
    assign bus_in = force_zero ? 8'h00 : ((cw_out == CW_R) ? tb_mem[addr_out] : 8'h00);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the next expected {addr,data}
    always @(negedge clk) begin
        if (!rst && busy) busy_cnt++;
        if (!rst && cw_oe && cw_out == CW_W) begin
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", {16'h0, addr_out}, 32'hFFFF_FFFF);
            end else begin
                logic [23:0] e;
                e = exp_q.pop_front();
                check("strobe_addr", {16'h0, addr_out}, {16'h0, e[23:8]});
                check("strobe_data", {24'h0, data_out}, {24'h0, e[7:0]});
                check("strobe_ctrlen", {31'h0, ctrlen}, 32'h0);
                tb_mem[addr_out] = data_out;
            end
        end
    end

    // Drivers
    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        cmd_data  = b;
        cmd_valid = 1'b1;
        while (cmd_ready !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 200) check("send_timeout", 32'(waited), 32'd0);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int waited = 0;
        @(negedge clk);
        while (!(cmd_ready === 1'b1 && busy === 1'b0) && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 2000) check("idle_timeout", 32'(waited), 32'd0);
    endtask

    task automatic set_addr(input logic [15:0] a);
        send_byte(OP_SET_ADDR);
        send_byte(a[7:0]);
        send_byte(a[15:8]);
        m_addr = a;
    endtask

    // Sends WRITE with the bytes queued in wr_data and records expected writes
    task automatic do_write();
        int n;
        n = wr_data.size();
        send_byte(OP_WRITE);
        send_byte(8'(n));
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({m_addr, wr_data[i]});
            m_addr = m_addr + 16'd1;
            send_byte(wr_data[i]);
        end
        wr_data.delete();
        m_owned = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          was_owned;
        int          n;
        logic [15:0] ra;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_data  = 8'h00;
        m_addr    = 16'h0000;
        m_owned   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ctrlen", {31'h0, ctrlen}, 32'h1);
        check("rst_cmd_ready", {31'h0, cmd_ready}, 32'h0);
        check("rst_oe", {29'h0, cw_oe, addr_oe, data_oe}, 32'h0);
        check("rst_cw_out", cw_out, 32'h0);
        check("rst_addr_data", {8'h0, addr_out, data_out}, 32'h0);
        check("rst_busy_err", {30'h0, busy, err}, 32'h0);
        check("rst_state", 32'(state_dbg), 32'(IDLE));
        rst = 1'b0;
        #1;
        check("ready_low_after_rst", {31'h0, cmd_ready}, 32'h0);
        @(posedge clk);
        #1;
        check("ready_rises", {31'h0, cmd_ready}, 32'h1);

        // SET_ADDR 1234, WRITE 1 byte AA with implicit take
        set_addr(16'h1234);
        send_byte(OP_WRITE);
        send_byte(8'h01);
        exp_q.push_back({16'h1234, 8'hAA});
        m_addr = 16'h1235;
        send_byte(8'hAA);
        check("t1_take_ctrlen", {31'h0, ctrlen}, 32'h0);
        check("t1_take_state", 32'(state_dbg), 32'(TAKE));
        check("t1_take_oe", {31'h0, addr_oe}, 32'h0);
        @(posedge clk); #1;
        check("t1_take2_ctrlen", {31'h0, ctrlen}, 32'h0);
        check("t1_take2_oe", {29'h0, cw_oe, addr_oe, data_oe}, 32'h0);
        @(posedge clk); #1;
        check("t1_setup_state", 32'(state_dbg), 32'(WR_SETUP));
        check("t1_setup_oe", {29'h0, cw_oe, addr_oe, data_oe}, 32'h7);
        check("t1_setup_cw", cw_out, 32'h0);
        check("t1_setup_bus", {8'h0, addr_out, data_out}, 32'h0012_34AA);
        @(posedge clk); #1;
        check("t1_strobe_cw", cw_out, CW_W);
        @(posedge clk); #1;
        check("t1_hold_cw", cw_out, 32'h0);
        check("t1_hold_oe", {30'h0, addr_oe, data_oe}, 32'h3);
`ifdef PROG_LOADER_VERIFY_EN
        @(posedge clk); #1;
        check("t1_verify1", {cw_out[30:0], data_oe}, {CW_R[30:0], 1'b0});
        @(posedge clk); #1;
        check("t1_verify2", {cw_out[30:0], data_oe}, {CW_R[30:0], 1'b0});
`endif
        @(posedge clk); #1;
        check("t1_done_ready_busy", {30'h0, cmd_ready, busy}, 32'h2);
        check("t1_done_owned", {30'h0, ctrlen, cw_oe}, 32'h1);
        m_owned = 1'b1;

        // Address wrap: FFFE, FFFF, 0000, then one more byte lands on 0001
        set_addr(16'hFFFE);
        busy_cnt = 0;
        wr_data = '{8'h11, 8'h22, 8'h33};
        do_write();
        wait_idle();
        check("t2_busy_per_byte", 32'(busy_cnt), 32'(3 * PER));
        wr_data = '{8'h44};
        do_write();
        wait_idle();
        check("t2_queue_drained", 32'(exp_q.size()), 32'd0);
        check("t2_model_addr", {16'h0, m_addr}, 32'h0002);

        // Bad opcode while released
        send_byte(OP_RELEASE);
        m_owned = 1'b0;
        check("t3_release_ctrlen", {31'h0, ctrlen}, 32'h1);
        send_byte(8'h7F);
        check("t3_err", {31'h0, err}, 32'h1);
        check("t3_no_oe", {29'h0, cw_oe, addr_oe, data_oe}, 32'h0);
        check("t3_idle", {30'h0, cmd_ready, busy}, 32'h2);

        // TAKE, RELEASE, RELEASE
        send_byte(OP_TAKE);
        check("t5_take_c1", {30'h0, ctrlen, busy}, 32'h1);
        @(posedge clk); #1;
        check("t5_take_c2", {30'h0, ctrlen, busy}, 32'h1);
        @(posedge clk); #1;
        check("t5_owned", {29'h0, ctrlen, busy, cw_oe}, 32'h1);
        send_byte(OP_RELEASE);
        check("t5_rel1", {28'h0, ctrlen, cw_oe, addr_oe, data_oe}, 32'h8);
        check("t5_rel1_busy", {31'h0, busy}, 32'h0);
        send_byte(OP_RELEASE);
        check("t5_rel2", {28'h0, ctrlen, cw_oe, busy, err}, 32'h9);

        // Reset during WR_STROBE
        send_byte(OP_TAKE);
        wait_idle();
        set_addr(16'h1000);
        send_byte(OP_WRITE);
        send_byte(8'h02);
        send_byte(8'hDE);
        check("t4_setup_state", 32'(state_dbg), 32'(WR_SETUP));
        @(posedge clk); #1;
        check("t4_strobe_cw", cw_out, CW_W);
        rst = 1'b1;
        #1;
        check("t4_rst_ctrlen", {31'h0, ctrlen}, 32'h1);
        check("t4_rst_cw", {cw_out[30:0], cw_oe}, 32'h0);
        check("t4_rst_err", {31'h0, err}, 32'h0);
        check("t4_rst_ready_busy", {30'h0, cmd_ready, busy}, 32'h0);
        exp_q.delete();
        m_addr  = 16'h0000;
        m_owned = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        wr_data = '{8'hC3};
        do_write();
        wait_idle();
        check("t4_after_rst_write", 32'(exp_q.size()), 32'd0);

        // Randomized write bursts with optional release in between
        for (int it = 0; it < 6; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                send_byte(OP_RELEASE);
                m_owned = 1'b0;
            end
            was_owned = m_owned;
            ra = 16'($urandom);
            set_addr(ra);
            n = $urandom_range(1, 5);
            for (int k = 0; k < n; k++) wr_data.push_back(8'($urandom));
            busy_cnt = 0;
            do_write();
            wait_idle();
            check("rnd_busy", 32'(busy_cnt), 32'((was_owned ? 0 : SETTLE) + n * PER));
            check("rnd_owned_ctrlen", {30'h0, ctrlen, cw_oe}, 32'h1);
            check("rnd_drained", 32'(exp_q.size()), 32'd0);
        end

        // n = 0 means 256 bytes
        set_addr(16'h00F0);
        for (int k = 0; k < 256; k++) wr_data.push_back(8'($urandom));
        busy_cnt = 0;
        do_write();
        wait_idle();
        check("n0_busy", 32'(busy_cnt), 32'(256 * PER));
        check("n0_drained", 32'(exp_q.size()), 32'd0);
        check("err_clear_before_verify", {31'h0, err}, 32'h0);

`ifdef PROG_LOADER_VERIFY_EN
        force_zero = 1'b1;
        set_addr(16'h2000);
        wr_data = '{8'h5A};
        busy_cnt = 0;
        do_write();
        wait_idle();
        force_zero = 1'b0;
        check("verify_err", {31'h0, err}, 32'h1);
        check("verify_busy", 32'(busy_cnt), 32'(PER));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Host-side master for the CPU's external control interface; it is the opposite end of the control word path.
- Normally the CPU's control logic drives control_word. This block deasserts ctrlen, takes over control_word, addr_bus and main_bus, and writes a byte stream into memory.
- It then hands the buses back so the CPU can run.
- Sits beside cpu in the emulator top. The top turns each *_oe output into a tri-state drive.

Parameters:
- CW_MEM_WRITE, 32'h0000_0000, control word asserted during the memory write strobe; the top overrides it with the real encoding.
- CW_MEM_READ, 32'h0000_0000, control word for a memory read onto main_bus; used only with the verify feature.
- SETTLE_CYCLES, 2, idle cycles after ctrlen falls before the first bus drive; range 1..15.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_data  in  8  host command/data byte.
- cmd_valid  in  1  cmd_data is valid.
- cmd_ready  out  1  byte accepted on a cycle where cmd_valid and cmd_ready are both high.
- ctrlen  out  1  1 = CPU control logic drives control_word; 0 = this block owns the buses.
- cw_out  out  32  control word value.
- cw_oe  out  1  drive cw_out onto control_word.
- addr_out  out  16  memory address.
- addr_oe  out  1  drive addr_bus.
- data_out  out  8  write data.
- data_oe  out  1  drive main_bus.
- bus_in  in  8  main_bus sampled value; used only with the verify feature.
- busy  out  1  high in any state other than IDLE and ARG.
- err  out  1  sticky error flag; cleared only by rst.

Behaviour:
- Reset values:
  - ctrlen=1, cmd_ready=0, all *_oe=0, cw_out=0, addr_out=0, data_out=0, busy=0, err=0.
  - Internal: addr=16'h0000, owned=0, state=IDLE.
  - cmd_ready rises on the first cycle after rst deasserts.
- Command stream (first byte is the opcode):
  - 8'h01 SET_ADDR + lo + hi: loads addr. No bus activity.
  - 8'h02 WRITE + n + n data bytes: n=0 means 256 bytes. Each data byte goes to addr, then addr increments; 16'hFFFF wraps to 16'h0000.
  - 8'h03 TAKE: if not owned, drive ctrlen=0 and wait SETTLE_CYCLES; then owned=1.
  - 8'h04 RELEASE: ctrlen=1, all *_oe=0 in the same cycle, owned=0. Issued while not owned, it is a no-op.
  - Any other opcode: err=1, byte discarded; the parser stays in IDLE.
- States: IDLE, ARG, TAKE, WR_SETUP, WR_STROBE, WR_HOLD, and VERIFY when enabled.
  - IDLE -> ARG on an opcode that takes arguments.
  - ARG -> IDLE after the last argument of SET_ADDR.
  - ARG -> WR_SETUP after each WRITE data byte.
  - A WRITE data byte arriving while not owned: TAKE runs first (implicit take), then WR_SETUP.
  - WR_SETUP -> WR_STROBE -> WR_HOLD -> ARG; returns to IDLE when the byte count reaches 0.
- cmd_ready is high only in IDLE and ARG. Exactly one byte is accepted per ready&valid cycle.
- Write cycle timing (3 cycles per byte, owned):
  - WR_SETUP: addr_oe=data_oe=1 with addr/data stable, cw_oe=1, cw_out=0.
  - WR_STROBE: cw_out=CW_MEM_WRITE.
  - WR_HOLD: cw_out=0; addr and data still driven.
  - After HOLD, the *_oe outputs stay high while owned, to avoid bus float.
  - Edge case: WRITE with n bytes at addr 16'hFFFE writes FFFE, FFFF, 0000, …
- ctrlen is 0 exactly while in TAKE or owned=1.
- Reset mid-operation: immediate return to reset values. The cycle in progress is aborted, and the CPU regains the buses asynchronously.

Optional Feature:
- Macro: PROG_LOADER_VERIFY_EN.
- Defined:
  - After WR_HOLD, the VERIFY state runs for 2 cycles with data_oe=0 and cw_out=CW_MEM_READ.
  - bus_in is sampled on the 2nd cycle.
  - A mismatch against the written byte sets err=1 and is recorded by sticking; the write sequence still continues.
  - Cost per byte rises to 5 cycles.
- Not defined: the VERIFY state does not exist, bus_in is ignored, and CW_MEM_READ is unused.

Decomposition:
- Package prog_loader_pkg:
  - Opcode constants OP_SET_ADDR, OP_WRITE, OP_TAKE, OP_RELEASE.
  - State enum.
  - Default control word constants.
- Sub-module mem_write_seq: the SETUP/STROBE/HOLD(/VERIFY) sequencer. It takes start, addr, data and returns done and mismatch.
- The top module holds the command parser, the address counter and ownership.

Test Plan:
- SET_ADDR 01,34,12 then WRITE 02,01,AA:
  - Implicit take: ctrlen falls, then after 2 idle cycles WR_SETUP.
  - addr_out=16'h1234, data_out=8'hAA.
  - cw_out=CW_MEM_WRITE for exactly 1 cycle.
- SET_ADDR FFFE, WRITE 3 bytes 11,22,33 -> strobes at FFFE, FFFF, 0000; final addr=16'h0001.
- Opcode 8'h7F -> err=1, no *_oe asserted, next valid command still executes.
- rst pulsed during WR_STROBE -> same cycle: ctrlen=1, cw_oe=0, err=0, and the next byte after reset is parsed as an opcode.
- TAKE, RELEASE, RELEASE -> ctrlen 1→0→1; the second RELEASE changes nothing; busy high only during TAKE.
- With PROG_LOADER_VERIFY_EN, bus_in forced to 8'h00 for a write of 8'h5A -> err=1, 5 cycles per byte.
